weighted_mean_calc: RTL and testbench
=====================================

WEIGHTED_MEAN_CALC -- requirements
Module: weighted_mean_calc

Interface
REQ-001 Parameter: DW, 32, width of each value and weight input and of the mean output.
REQ-002 Parameter: NUM, 4, number of value/weight pairs (fixed at 4; other values unsupported).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 x1, x2, x3, x4  input  DW each  unsigned sample values.
REQ-006 w1, w2, w3, w4  input  DW each  unsigned weights paired with x1..x4.
REQ-007 in_valid  input  1  x/w inputs valid this cycle.
REQ-008 in_ready  output  1  block idle and able to accept an input set.
REQ-009 mean  output  DW  floor(sum(wi*xi) / sum(wi)).
REQ-010 weight_sum  output  DW+2  sum(wi) of the set that produced mean.
REQ-011 div_by_zero  output  1  set when all four weights were zero.
REQ-012 out_valid  output  1  mean/weight_sum/div_by_zero valid.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 States: IDLE, MAC, DIV, DONE; the block processes one input set at a time, with no overlap.
REQ-015 in_ready is 1 only in IDLE; transfer on a clock edge where in_valid and in_ready are both 1; all eight inputs are registered on that edge; state goes to MAC.
REQ-016 MAC: 4 cycles, one pair per cycle in order 1..4.
- Accumulator num (2*DW+2 bits): num += wi*xi, with a full 2*DW-bit product.
- Accumulator wsum (DW+2 bits): wsum += wi.
- Both accumulators are cleared on accept.
REQ-017 No truncation or overflow is allowed in num or wsum for any input values.
REQ-018 After the 4th MAC step, go to DONE if wsum==0; otherwise go to DIV.
REQ-019 DIV: restoring unsigned division of num by wsum, one quotient bit per cycle, MSB first, 2*DW+2 cycles (66 for DW=32).
REQ-020 mean = low DW bits of the quotient; the upper bits are zero by construction (mean <= max xi); remainder discarded (floor rounding).
REQ-021 Zero weights: mean=0, div_by_zero=1, weight_sum=0, DIV skipped.
REQ-022 DONE: out_valid=1, and outputs are held stable until a cycle with out_ready=1; on that edge go to IDLE and set out_valid=0.
REQ-023 Latency from the accept edge E0: out_valid first seen high after edge E0+70 (DW=32, nonzero weights) or after E0+4 (zero weights).
REQ-024 Minimum spacing between accepts: latency + 1 cycle (the result must be consumed first).
REQ-025 in_valid while not in IDLE is ignored; no input is captured.
REQ-026 out_ready outside DONE has no effect.
REQ-027 Input changes after the accept edge do not affect the result in progress.

Reset
REQ-028 On reset=1 at a clock edge, from any state (including mid-MAC or mid-DIV):
- state goes to IDLE;
- mean, weight_sum, div_by_zero, out_valid, num, wsum and divider registers are all cleared to 0;
- in_ready=1 in the following cycle.
REQ-029 Reset has priority over the in_valid/out_ready handshakes in the same cycle; the in-flight operation is discarded and no out_valid pulse is produced.

Structure
REQ-030 Package weighted_mean_pkg holds:
- DW and NUM defaults;
- derived widths NUM_W=2*DW+2 and WSUM_W=DW+2;
- the state enumeration (IDLE, MAC, DIV, DONE).
REQ-031 One sub-module, seq_div: a restoring sequential divider.
- Interface: start, dividend, divisor, busy, done, quotient.
- Instantiated once; the FSM and MAC datapath stay in weighted_mean_calc.
REQ-032 Exactly one DWxDW multiplier is used, time-shared across the MAC steps.

Verification
REQ-033 x=(10,20,30,40), w=(1,1,1,1) -> mean=25, weight_sum=4, div_by_zero=0, out_valid after E0+70.
REQ-034 x=(1,2,3,4), w=(2,3,1,3) -> num=23, mean=2 (floor), weight_sum=9.
REQ-035 All x=0xFFFFFFFF, all w=0xFFFFFFFF -> mean=0xFFFFFFFF, weight_sum=0x3FFFFFFFC; no overflow.
REQ-036 w=(0,0,0,0), x arbitrary -> mean=0, div_by_zero=1, out_valid after E0+4.
REQ-037 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, second set not captured; out_ready=1 -> IDLE next cycle, then the second set is accepted.
REQ-038 Assert reset at E0+30 (mid-DIV) -> all outputs 0 next cycle, no out_valid pulse; a new set then completes correctly.

Source files
------------

// File: rtl/weighted_mean_pkg.sv
// Shared widths and state encoding for the weighted mean calculator.
package weighted_mean_pkg;

    localparam int DW_DEF  = 32;
    localparam int NUM_DEF = 4;

    // Numerator accumulator holds four full products plus two growth bits,
    // weight sum holds four weights plus two growth bits.
    localparam int NUM_W  = 2 * DW_DEF + 2;
    localparam int WSUM_W = DW_DEF + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/weighted_mean_calc_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The start cycle already performs the first step, so a full division
// occupies NW consecutive edges, and done pulses the cycle after the last one.
module seq_div
    import weighted_mean_pkg::*;
#(
    parameter int NW  = NUM_W,
    parameter int DVW = WSUM_W,
    parameter int QW  = DW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [NW-1:0]  dividend,
    input  logic [DVW-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [QW-1:0]  quotient
);

    localparam int CW = $clog2(NW + 1);

    logic [DVW-1:0] rem_q;
    logic [DVW-1:0] divisor_q;
    logic [NW-1:0]  quot_q;
    logic [CW-1:0]  count_q;

    logic [DVW-1:0] src_rem;
    logic [NW-1:0]  src_quot;
    logic [DVW-1:0] src_div;
    logic [DVW:0]   shifted;
    logic [DVW:0]   diff;
    logic           fits;
    logic [DVW-1:0] step_rem;
    logic [NW-1:0]  step_quot;

    // One restoring step, fed from the inputs on start or from the registers otherwise
    always_comb begin
        src_rem   = start ? '0 : rem_q;
        src_quot  = start ? dividend : quot_q;
        src_div   = start ? divisor : divisor_q;
        shifted   = {src_rem, src_quot[NW-1]};
        diff      = shifted - {1'b0, src_div};
        fits      = (shifted >= {1'b0, src_div});
        step_rem  = fits ? diff[DVW-1:0] : shifted[DVW-1:0];
        step_quot = {src_quot[NW-2:0], fits};
    end

    // Step register: the dividend shifts out of quot_q while quotient bits shift in
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            count_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q     <= step_rem;
                quot_q    <= step_quot;
                divisor_q <= divisor;
                count_q   <= CW'(NW - 1);
                busy      <= 1'b1;
            end else if (busy) begin
                rem_q   <= step_rem;
                quot_q  <= step_quot;
                count_q <= count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Quotient is bounded by the largest sample, so only the low bits carry information
    assign quotient = quot_q[QW-1:0];

endmodule

// File: rtl/weighted_mean_calc.sv
// Weighted mean: floor(sum(wi*xi) / sum(wi)) over four pairs, using a single
// time-shared multiplier for the MAC phase and a sequential divider.
module weighted_mean_calc
    import weighted_mean_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int NUM = NUM_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] x1,
    input  logic [DW-1:0] x2,
    input  logic [DW-1:0] x3,
    input  logic [DW-1:0] x4,
    input  logic [DW-1:0] w1,
    input  logic [DW-1:0] w2,
    input  logic [DW-1:0] w3,
    input  logic [DW-1:0] w4,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] mean,
    output logic [DW+1:0] weight_sum,
    output logic          div_by_zero,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int NW = 2 * DW + 2;
    localparam int WW = DW + 2;

    state_t state_q, state_d;

    logic [DW-1:0]   x_q [NUM];
    logic [DW-1:0]   w_q [NUM];
    logic [1:0]      step_q;
    logic [NW-1:0]   num_q;
    logic [WW-1:0]   wsum_q;

    logic [DW-1:0]   x_sel;
    logic [DW-1:0]   w_sel;
    logic [2*DW-1:0] prod;
    logic [NW-1:0]   num_next;
    logic [WW-1:0]   wsum_next;
    logic            last_step;

    logic            div_start;
    logic            div_busy;
    logic            div_done;
    logic [DW-1:0]   div_quot;

    // Single multiplier, its operands selected by the current MAC step
    always_comb begin
        x_sel     = x_q[step_q];
        w_sel     = w_q[step_q];
        prod      = {{DW{1'b0}}, x_sel} * {{DW{1'b0}}, w_sel};
        num_next  = num_q + {2'b00, prod};
        wsum_next = wsum_q + {2'b00, w_sel};
        last_step = (step_q == 2'(NUM - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = MAC;
            MAC:  if (last_step) state_d = (wsum_next == '0) ? DONE : DIV;
            DIV:  if (div_done) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs and divider kick-off on the final MAC step
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        div_start = (state_q == MAC) && last_step && (wsum_next != '0);
    end

    // Input capture, accumulation and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
            step_q      <= '0;
            num_q       <= '0;
            wsum_q      <= '0;
            mean        <= '0;
            weight_sum  <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q[0] <= x1; x_q[1] <= x2; x_q[2] <= x3; x_q[3] <= x4;
                        w_q[0] <= w1; w_q[1] <= w2; w_q[2] <= w3; w_q[3] <= w4;
                        step_q <= '0;
                        num_q  <= '0;
                        wsum_q <= '0;
                    end
                end
                MAC: begin
                    num_q  <= num_next;
                    wsum_q <= wsum_next;
                    step_q <= step_q + 2'd1;
                    if (last_step && (wsum_next == '0)) begin
                        mean        <= '0;
                        weight_sum  <= '0;
                        div_by_zero <= 1'b1;
                    end
                end
                DIV: begin
                    if (div_done && !div_busy) begin
                        mean        <= div_quot;
                        weight_sum  <= wsum_q;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    seq_div #(
        .NW  (NW),
        .DVW (WW),
        .QW  (DW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (num_next),
        .divisor  (wsum_next),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

endmodule

// File: tb/tb_weighted_mean_calc.sv
// Directed testbench for weighted_mean_calc with hand-computed expectations.
module tb_weighted_mean_calc;

    logic        clk;
    logic        reset;
    logic [31:0] x1, x2, x3, x4;
    logic [31:0] w1, w2, w3, w4;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mean;
    logic [33:0] weight_sum;
    logic        div_by_zero;
    logic        out_valid;
    logic        out_ready;

    int pass_count;
    int check_count;

    weighted_mean_calc #(.DW(32), .NUM(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .x1          (x1),
        .x2          (x2),
        .x3          (x3),
        .x4          (x4),
        .w1          (w1),
        .w2          (w2),
        .w3          (w3),
        .w4          (w4),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mean        (mean),
        .weight_sum  (weight_sum),
        .div_by_zero (div_by_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic drive_set(input logic [31:0] a1, a2, a3, a4, b1, b2, b3, b4);
        x1 = a1; x2 = a2; x3 = a3; x4 = a4;
        w1 = b1; w2 = b2; w3 = b3; w4 = b4;
    endtask

    // Present one set for a single edge (the accept edge E0), then drop in_valid
    task automatic accept_set(input logic [31:0] a1, a2, a3, a4, b1, b2, b3, b4);
        @(negedge clk);
        drive_set(a1, a2, a3, a4, b1, b2, b3, b4);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after E0 until out_valid is seen; bounded
    task automatic wait_result(input string name, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!out_valid) begin
            check_count++;
            $display("[TB] FAIL %s timeout: out_valid never rose within %0d cycles", name, cycles);
        end
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_count++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL %s consume: in_ready=%b out_valid=%b, required 1/0", name, in_ready, out_valid);
        else pass_count++;
    endtask

    task automatic check_result(input string name, input int cycles, input int exp_cycles,
                                input logic [31:0] exp_mean, input logic [33:0] exp_wsum,
                                input logic exp_dbz);
        check_count++;
        if (cycles !== exp_cycles) $display("[TB] FAIL %s latency: got %0d, required %0d", name, cycles, exp_cycles);
        else pass_count++;
        check_count++;
        if (mean !== exp_mean) $display("[TB] FAIL %s mean: got 0x%h, required 0x%h", name, mean, exp_mean);
        else pass_count++;
        check_count++;
        if (weight_sum !== exp_wsum) $display("[TB] FAIL %s weight_sum: got 0x%h, required 0x%h", name, weight_sum, exp_wsum);
        else pass_count++;
        check_count++;
        if (div_by_zero !== exp_dbz) $display("[TB] FAIL %s div_by_zero: got %b, required %b", name, div_by_zero, exp_dbz);
        else pass_count++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_count++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mean !== 32'd0 || weight_sum !== 34'd0 || div_by_zero !== 1'b0)
            $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b mean=%0d weight_sum=%0d dbz=%b, required 1/0/0/0/0",
                     in_ready, out_valid, mean, weight_sum, div_by_zero);
        else pass_count++;
    endtask

    task automatic test_equal_weights();
        int cycles;
        accept_set(32'd10, 32'd20, 32'd30, 32'd40, 32'd1, 32'd1, 32'd1, 32'd1);
        check_count++;
        if (in_ready !== 1'b0) $display("[TB] FAIL equal busy: in_ready=%b, required 0", in_ready);
        else pass_count++;
        wait_result("equal", cycles);
        check_result("equal", cycles, 70, 32'd25, 34'd4, 1'b0);
        consume("equal");
    endtask

    task automatic test_floor();
        int cycles;
        accept_set(32'd1, 32'd2, 32'd3, 32'd4, 32'd2, 32'd3, 32'd1, 32'd3);
        // Later input changes must not disturb the set in progress
        drive_set(32'd999, 32'd999, 32'd999, 32'd999, 32'd7, 32'd7, 32'd7, 32'd7);
        wait_result("floor", cycles);
        check_result("floor", cycles, 70, 32'd2, 34'd9, 1'b0);
        consume("floor");
    endtask

    task automatic test_max();
        int cycles;
        accept_set(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_result("max", cycles);
        check_result("max", cycles, 70, 32'hFFFFFFFF, 34'h3FFFFFFFC, 1'b0);
        consume("max");
    endtask

    task automatic test_zero_weights();
        int cycles;
        accept_set(32'd5, 32'd6, 32'd7, 32'd8, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_result("zero_w", cycles);
        check_result("zero_w", cycles, 4, 32'd0, 34'd0, 1'b1);
        consume("zero_w");
    endtask

    task automatic test_mixed();
        int cycles;
        // (100*1 + 7*0 + 50*2 + 3*5) / 8 = 215/8 = 26
        accept_set(32'd100, 32'd7, 32'd50, 32'd3, 32'd1, 32'd0, 32'd2, 32'd5);
        wait_result("mixed", cycles);
        check_result("mixed", cycles, 70, 32'd26, 34'd8, 1'b0);
        consume("mixed");
    endtask

    task automatic test_back_to_back();
        int cycles;
        accept_set(32'd10, 32'd20, 32'd30, 32'd40, 32'd1, 32'd1, 32'd1, 32'd1);
        wait_result("hold", cycles);
        @(negedge clk);
        drive_set(32'd1, 32'd2, 32'd3, 32'd4, 32'd2, 32'd3, 32'd1, 32'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_count++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || mean !== 32'd25 || weight_sum !== 34'd4)
                $display("[TB] FAIL hold cycle %0d: out_valid=%b in_ready=%b mean=%0d wsum=%0d, required 1/0/25/4",
                         i, out_valid, in_ready, mean, weight_sum);
            else pass_count++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_count++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        else pass_count++;
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_count++;
        if (in_ready !== 1'b0) $display("[TB] FAIL second accept: in_ready=%b, required 0", in_ready);
        else pass_count++;
        wait_result("second", cycles);
        check_result("second", cycles, 70, 32'd2, 34'd9, 1'b0);
        consume("second");
    endtask

    task automatic test_reset_mid_div();
        int cycles;
        int seen;
        accept_set(32'd10, 32'd20, 32'd30, 32'd40, 32'd1, 32'd1, 32'd1, 32'd1);
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_count++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mean !== 32'd0 || weight_sum !== 34'd0 || div_by_zero !== 1'b0)
            $display("[TB] FAIL mid_div reset: in_ready=%b out_valid=%b mean=%0d wsum=%0d dbz=%b, required 1/0/0/0/0",
                     in_ready, out_valid, mean, weight_sum, div_by_zero);
        else pass_count++;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_count++;
        if (seen !== 0) $display("[TB] FAIL mid_div no pulse: out_valid high %0d cycles, required 0", seen);
        else pass_count++;
        accept_set(32'd8, 32'd16, 32'd0, 32'd4, 32'd3, 32'd1, 32'd4, 32'd0);
        wait_result("after_reset", cycles);
        // (24 + 16 + 0 + 0) / 8 = 5
        check_result("after_reset", cycles, 70, 32'd5, 34'd8, 1'b0);
        consume("after_reset");
    endtask

    // Test sequence
    initial begin
        clk         = 1'b0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        pass_count  = 0;
        check_count = 0;
        drive_set('0, '0, '0, '0, '0, '0, '0, '0);

        test_reset();
        test_equal_weights();
        test_floor();
        test_max();
        test_zero_weights();
        test_mixed();
        test_back_to_back();
        test_reset_mid_div();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
